// File: rtl/snes_pad_poller.sv
// SNES controller port master: drives latch/clock, samples d0/d1 and returns two button words per poll.
// Optional build macro POLLER_AUTO_EN adds a free-running AUTO_PERIOD poll timer.
module snes_pad_poller #(
  parameter int LATCH_CYCLES = 144,
  parameter int HALF_CYCLES  = 72,
  parameter int NUM_BITS     = 16,
  parameter int AUTO_PERIOD  = 200000
) (
  input  logic                i_sys_clk_12,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_d0,
  input  logic                i_d1,
  output logic                o_latch,
  output logic                o_clk,
  output logic                o_busy,
  output logic                o_valid,
  output logic [NUM_BITS-1:0] o_d0_word,
  output logic [NUM_BITS-1:0] o_d1_word
);

  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BIT_W  = $clog2(NUM_BITS) + 1;

  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LIMIT  = BIT_W'(NUM_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [PH_W-1:0]   phase_reg, phase_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic              sample_now;
  logic              start_req;
  logic              auto_req;

  logic [1:0]          meta_reg;
  logic [1:0]          sync_reg;
  logic [NUM_BITS-1:0] shift0_reg;
  logic [NUM_BITS-1:0] shift1_reg;

  logic latch_next, clk_next, busy_next, valid_next;

  // Data lines are asynchronous to the system clock; idle level is high (not pressed).
  always_ff @(posedge i_sys_clk_12) begin
    if (i_reset) begin
      meta_reg <= 2'b11;
      sync_reg <= 2'b11;
    end else begin
      meta_reg <= {i_d1, i_d0};
      sync_reg <= meta_reg;
    end
  end

`ifdef POLLER_AUTO_EN
  localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_reg;

  always_ff @(posedge i_sys_clk_12) begin
    if (i_reset) begin
      auto_reg <= '0;
    end else if (auto_reg == AUTO_LAST) begin
      auto_reg <= '0;
    end else begin
      auto_reg <= auto_reg + 1'b1;
    end
  end

  // Only honoured in IDLE, so a wrap that lands mid-poll is simply lost.
  assign auto_req = (auto_reg == AUTO_LAST);
`else
  assign auto_req = (AUTO_PERIOD < 0);
`endif

  assign start_req = i_start | auto_req;

  always_ff @(posedge i_sys_clk_12) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
      phase_reg <= '0;
      bit_reg   <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      bit_reg   <= bit_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg + 1'b1;
    bit_next   = bit_reg;
    sample_now = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        phase_next = '0;
        bit_next   = '0;
        if (start_req) begin
          state_next = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (phase_reg == LATCH_LAST) begin
          state_next = ST_GAP;
          phase_next = '0;
        end
      end
      ST_GAP: begin
        if (phase_reg == HALF_LAST) begin
          state_next = ST_CLK_LO;
          phase_next = '0;
        end
      end
      ST_CLK_LO: begin
        if (phase_reg == HALF_LAST) begin
          state_next = ST_CLK_HI;
          phase_next = '0;
          sample_now = 1'b1;
        end
      end
      ST_CLK_HI: begin
        if (phase_reg == HALF_LAST) begin
          phase_next = '0;
          bit_next   = bit_reg + 1'b1;
          if (bit_next < BIT_LIMIT) begin
            state_next = ST_CLK_LO;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        phase_next = '0;
        bit_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
        phase_next = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with state_reg.
  always_comb begin
    latch_next = (state_next == ST_LATCH);
    clk_next   = (state_next != ST_CLK_LO);
    busy_next  = (state_next != ST_IDLE);
    valid_next = (state_next == ST_DONE);
  end

  // Wire-low means pressed, so samples are inverted; first bit ends up in the MSB.
  always_ff @(posedge i_sys_clk_12) begin
    if (i_reset) begin
      shift0_reg <= '0;
      shift1_reg <= '0;
    end else if (sample_now) begin
      shift0_reg <= {shift0_reg[NUM_BITS-2:0], ~sync_reg[0]};
      shift1_reg <= {shift1_reg[NUM_BITS-2:0], ~sync_reg[1]};
    end
  end

  always_ff @(posedge i_sys_clk_12) begin
    if (i_reset) begin
      o_latch   <= 1'b0;
      o_clk     <= 1'b1;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_d0_word <= '0;
      o_d1_word <= '0;
    end else begin
      o_latch <= latch_next;
      o_clk   <= clk_next;
      o_busy  <= busy_next;
      o_valid <= valid_next;
      if (state_next == ST_DONE) begin
        o_d0_word <= shift0_reg;
        o_d1_word <= shift1_reg;
      end
    end
  end

endmodule

// File: tb/tb_snes_pad_poller.sv
// Bench for snes_pad_poller: a behavioural pad drives d0/d1 and each poll is checked for words and timing.
module tb_snes_pad_poller;

  localparam int LATCH  = 144;
  localparam int HALF   = 72;
  localparam int NBITS  = 16;
  localparam int AUTO_P = 5000;
  localparam int LAT    = LATCH + HALF + NBITS * 2 * HALF + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        d0;
  logic        d1;
  logic        o_latch;
  logic        o_clk;
  logic        o_busy;
  logic        o_valid;
  logic [15:0] o_d0_word;
  logic [15:0] o_d1_word;

  snes_pad_poller #(
    .LATCH_CYCLES(LATCH),
    .HALF_CYCLES (HALF),
    .NUM_BITS    (NBITS),
    .AUTO_PERIOD (AUTO_P)
  ) dut (
    .i_sys_clk_12(clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_d0        (d0),
    .i_d1        (d1),
    .o_latch     (o_latch),
    .o_clk       (o_clk),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_d0_word   (o_d0_word),
    .o_d1_word   (o_d1_word)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int poll_no  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pad model: latch reloads, each rising clock advances; the wire carries the inverted button bit.
  logic [15:0] pad0 = 16'h0000;
  logic [15:0] pad1 = 16'h0000;
  int          pad_idx = 16;
  logic        pad_clk_prev = 1'b1;
  int          hold_mode = 0;

  always @(negedge clk) begin
    if (o_latch) pad_idx = 0;
    else if (o_clk && !pad_clk_prev) pad_idx++;
    pad_clk_prev = o_clk;
    if (hold_mode == 1) begin
      d0 = 1'b0; d1 = 1'b0;
    end else if (hold_mode == 2) begin
      d0 = 1'b1; d1 = 1'b1;
    end else if (pad_idx < 16) begin
      d0 = ~pad0[15 - pad_idx];
      d1 = ~pad1[15 - pad_idx];
    end else begin
      d0 = 1'b0; d1 = 1'b0;
    end
  end

  function automatic logic [15:0] expect_word(input logic [15:0] w, input int mode);
    if (mode == 1) return 16'hFFFF;
    if (mode == 2) return 16'h0000;
    return w;
  endfunction

  task automatic do_poll(input logic [15:0] w0, input logic [15:0] w1, input int mode,
                         input bit extra_start);
    int cyc, valid_cnt, valid_at, latch_cnt, latch_first, falls, first_fall;
    int run_len, bad_runs, busy_after;
    logic prev_clk;
    logic [15:0] got0, got1, exp0, exp1;
    pad0 = w0; pad1 = w1; hold_mode = mode;
    exp0 = expect_word(w0, mode);
    exp1 = expect_word(w1, mode);
    check("idle_before", {31'd0, o_busy}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; valid_cnt = 0; valid_at = -10; latch_cnt = 0; latch_first = -1;
    falls = 0; first_fall = -1; run_len = 0; bad_runs = 0; busy_after = -1;
    prev_clk = 1'b1; got0 = '0; got1 = '0;
    while (cyc <= LAT + 80) begin
      start = (extra_start && cyc == 500);
      if (o_clk != prev_clk) begin
        if (!o_clk) begin
          falls++;
          if (first_fall < 0) first_fall = cyc;
          else if (run_len != HALF) bad_runs++;
        end else if (run_len != HALF) begin
          bad_runs++;
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_clk = o_clk;
      if (o_latch && !o_clk) bad_runs++;
      if (o_latch) begin
        latch_cnt++;
        if (latch_first < 0) latch_first = cyc;
      end
      if (o_valid) begin
        valid_cnt++;
        valid_at = cyc;
        got0 = o_d0_word;
        got1 = o_d1_word;
      end
      if (cyc == valid_at + 1) busy_after = int'(o_busy);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    poll_no++;
    $display("poll %0d: d0=%h d1=%h valid_at=%0d falls=%0d", poll_no, got0, got1, valid_at, falls);
    check("valid_count", valid_cnt, 1);
    check("valid_latency", valid_at, LAT);
    check("d0_word", {16'd0, got0}, {16'd0, exp0});
    check("d1_word", {16'd0, got1}, {16'd0, exp1});
    check("busy_after_valid", busy_after, 0);
    check("latch_len", latch_cnt, LATCH);
    check("latch_first", latch_first, 1);
    check("first_fall", first_fall, LATCH + HALF + 1);
    check("clk_falls", falls, NBITS);
    check("clk_phases", bad_runs, 0);
    repeat (20) @(negedge clk);
    check("d0_hold", {16'd0, o_d0_word}, {16'd0, exp0});
    check("d1_hold", {16'd0, o_d1_word}, {16'd0, exp1});
  endtask

  task automatic reset_mid_poll();
    int cyc, falls;
    logic prev;
    pad0 = $urandom; pad1 = $urandom; hold_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; falls = 0;
    while (falls < 8 && cyc < 3000) begin
      prev = o_clk;
      @(negedge clk);
      cyc++;
      if (prev && !o_clk) falls++;
    end
    check("reach_8th_clk_lo", {31'd0, falls == 8}, 32'd1);
    repeat (10) @(negedge clk);
    check("pre_reset_clk_low", {31'd0, o_clk}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-poll: latch=%b clk=%b busy=%b d0=%h d1=%h",
             o_latch, o_clk, o_busy, o_d0_word, o_d1_word);
    check("rst_latch", {31'd0, o_latch}, 32'd0);
    check("rst_clk", {31'd0, o_clk}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_d0", {16'd0, o_d0_word}, 32'd0);
    check("rst_d1", {16'd0, o_d1_word}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; d0 = 1'b1; d1 = 1'b1;
    repeat (3) @(negedge clk);
    $display("reset: latch=%b clk=%b busy=%b valid=%b d0=%h d1=%h",
             o_latch, o_clk, o_busy, o_valid, o_d0_word, o_d1_word);
    check("reset_latch", {31'd0, o_latch}, 32'd0);
    check("reset_clk", {31'd0, o_clk}, 32'd1);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_d0", {16'd0, o_d0_word}, 32'd0);
    check("reset_d1", {16'd0, o_d1_word}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

`ifdef POLLER_AUTO_EN
    begin
      int cyc, n_valid, last_at, bad_gap;
      pad0 = $urandom; pad1 = $urandom; hold_mode = 0;
      cyc = 0; n_valid = 0; last_at = -1; bad_gap = 0;
      while (cyc < 4 * AUTO_P && n_valid < 3) begin
        @(negedge clk);
        cyc++;
        if (o_valid) begin
          n_valid++;
          $display("auto poll at cycle %0d: d0=%h d1=%h", cyc, o_d0_word, o_d1_word);
          check("auto_d0", {16'd0, o_d0_word}, {16'd0, pad0});
          check("auto_d1", {16'd0, o_d1_word}, {16'd0, pad1});
          if (last_at >= 0 && cyc - last_at != AUTO_P) bad_gap++;
          last_at = cyc;
        end
      end
      check("auto_pulses", n_valid, 3);
      check("auto_period", bad_gap, 0);
    end
`else
    do_poll(16'h8001, 16'h1234, 0, 1'b0);
    do_poll(16'hA5C3, 16'h0F0F, 0, 1'b1);
    do_poll(16'h7E18, 16'hC001, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_poll(16'($urandom), 16'($urandom), 0, 1'b0);
    end
    reset_mid_poll();
    do_poll(16'h0000, 16'h0000, 1, 1'b0);
    do_poll(16'hFFFF, 16'hFFFF, 2, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
